// File: rtl/type_t_sram_stream_fifo.sv
// Streaming FIFO controller for a double-ported type T SRAM macro.
// Full-row writes come from the input stream; rows are prefetched into a 3-entry skid buffer.
module type_t_sram_stream_fifo #(
  parameter int WIDTH    = 128,
  parameter int NUM_ROWS = 4096,
  localparam int AddressWidth = $clog2(NUM_ROWS),
  localparam int CountWidth   = $clog2(NUM_ROWS + 4)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CountWidth-1:0]   count,
  output logic                    sram_reb,
  output logic                    sram_web,
  output logic [AddressWidth-1:0] sram_aa,
  output logic [AddressWidth-1:0] sram_ab,
  output logic [WIDTH-1:0]        sram_d,
  output logic [WIDTH-1:0]        sram_m,
  input  logic [WIDTH-1:0]        sram_q
);

  logic [AddressWidth-1:0] wr_ptr;
  logic [AddressWidth-1:0] rd_ptr;
  logic [CountWidth-1:0]   sram_cnt;
  logic                    rd_inflight;
  logic [WIDTH-1:0]        skid_mem [3];
  logic [1:0]              head;
  logic [1:0]              tail;
  logic [1:0]              buf_cnt;
  logic                    push;
  logic                    issue;
  logic                    pop;

  function automatic logic [AddressWidth-1:0] inc_ptr(input logic [AddressWidth-1:0] p);
    return (p == AddressWidth'(NUM_ROWS - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [1:0] inc_slot(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  assign in_ready = (sram_cnt < CountWidth'(NUM_ROWS));
  assign push     = in_valid & in_ready;
  // Reserve a skid slot for every read in flight so a returning row always has room.
  assign issue    = (sram_cnt != '0) & (({1'b0, buf_cnt} + {2'b00, rd_inflight}) < 3'd3);
  assign out_valid = (buf_cnt != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = skid_mem[head];

  assign sram_web = ~push;
  assign sram_aa  = wr_ptr;
  assign sram_d   = in_data;
  assign sram_m   = '0;
  assign sram_reb = ~issue;
  assign sram_ab  = rd_ptr;

  assign count = sram_cnt + CountWidth'(rd_inflight) + CountWidth'(buf_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sram_cnt    <= '0;
      rd_inflight <= 1'b0;
      head        <= 2'd0;
      tail        <= 2'd0;
      buf_cnt     <= 2'd0;
      for (int i = 0; i < 3; i++) skid_mem[i] <= '0;
    end else begin
      if (push)  wr_ptr <= inc_ptr(wr_ptr);
      if (issue) rd_ptr <= inc_ptr(rd_ptr);
      rd_inflight <= issue;
      sram_cnt    <= sram_cnt + CountWidth'(push) - CountWidth'(issue);
      if (rd_inflight) begin
        skid_mem[tail] <= sram_q;
        tail           <= inc_slot(tail);
      end
      if (pop) head <= inc_slot(head);
      buf_cnt <= buf_cnt + {1'b0, rd_inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_type_t_sram_stream_fifo.sv
// Scoreboard bench for type_t_sram_stream_fifo with a behavioural SRAM macro model.
module tb_type_t_sram_stream_fifo;
  localparam int W  = 16;
  localparam int NR = 5;
  localparam int AW = $clog2(NR);
  localparam int CW = $clog2(NR + 4);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          sram_reb, sram_web;
  logic [AW-1:0] sram_aa, sram_ab;
  logic [W-1:0]  sram_d, sram_m, sram_q;

  type_t_sram_stream_fifo #(.WIDTH(W), .NUM_ROWS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count),
    .sram_reb(sram_reb), .sram_web(sram_web), .sram_aa(sram_aa), .sram_ab(sram_ab),
    .sram_d(sram_d), .sram_m(sram_m), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [NR];
  always @(posedge clk) begin
    if (!sram_web) mem[sram_aa] <= sram_d;
    if (!sram_reb) sram_q <= mem[sram_ab];
  end

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q [$];
  int mdl_cnt = 0;
  int pops = 0;
  int exp_wa = 0;
  int exp_ra = 0;
  logic stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;
  logic [W-1:0] last_pop = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: scoreboard, count model, address sequence, collision and stall stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_cnt = 0; exp_wa = 0; exp_ra = 0; stall_prev = 1'b0;
    end else begin
      chk("count_model", 32'(count), 32'(mdl_cnt));
      if (mdl_cnt == 0) chk("empty_no_valid", 32'(out_valid), 0);
      chk("web_vs_push", 32'(sram_web), 32'(!(in_valid && in_ready)));
      if (!sram_web) begin
        chk("sram_aa_seq", 32'(sram_aa), 32'(exp_wa));
        chk("sram_d", 32'(sram_d), 32'(in_data));
        exp_wa = (exp_wa == NR - 1) ? 0 : exp_wa + 1;
      end
      if (!sram_reb) begin
        chk("sram_ab_seq", 32'(sram_ab), 32'(exp_ra));
        exp_ra = (exp_ra == NR - 1) ? 0 : exp_ra + 1;
      end
      if (!sram_web && !sram_reb && sram_aa == sram_ab) begin
        checks++; failures++;
        $display("FAIL collision aa=%0d ab=%0d", sram_aa, sram_ab);
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(stall_data));
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_pop got=%0h exp=none", out_data);
        end else begin
          chk("scoreboard_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        last_pop = out_data;
        pops++;
        mdl_cnt--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        mdl_cnt++;
      end
    end
  end

  task automatic push_word(input logic [W-1:0] d);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    while (!in_ready && t < 500) begin @(negedge clk); t++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout got=stalled exp=accepted");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    out_ready = 1'b1;
    while ((mdl_cnt != 0 || out_valid) && t < 500) begin @(negedge clk); t++; end
    chk(name, 32'(t < 500), 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin : main
    int lat, gaps, pbase, t;
    logic done_push;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_web", 32'(sram_web), 1);
    chk("rst_reb", 32'(sram_reb), 1);
    chk("rst_aa", 32'(sram_aa), 0);
    chk("rst_ab", 32'(sram_ab), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word latency
    in_valid = 1'b1; in_data = 16'h00A5;
    @(negedge clk);
    chk("t1_web_c0", 32'(sram_web), 0);
    chk("t1_aa_c0", 32'(sram_aa), 0);
    chk("t1_cnt_c0", 32'(count), 0);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("t1_reb_c1", 32'(sram_reb), 0);
    chk("t1_ab_c1", 32'(sram_ab), 0);
    chk("t1_cnt_c1", 32'(count), 1);
    @(negedge clk);
    chk("t1_valid_c2", 32'(out_valid), 0);
    chk("t1_cnt_c2", 32'(count), 1);
    @(negedge clk);
    chk("t1_valid_c3", 32'(out_valid), 1);
    chk("t1_data_c3", 32'(out_data), 32'h00A5);
    chk("t1_cnt_c3", 32'(count), 1);
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    chk("t1_cnt_c4", 32'(count), 1);
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    chk("t1_cnt_after_pop", 32'(count), 0);
    chk("t1_valid_after_pop", 32'(out_valid), 0);
    @(posedge clk); #1;

    // Fill to capacity NR+3 with output blocked
    for (int k = 1; k <= NR + 3; k++) push_word(W'(k));
    @(negedge clk);
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_count", 32'(count), NR + 3);
    chk("fill_reb_idle", 32'(sram_reb), 1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = W'(NR + 4);
    repeat (3) @(negedge clk);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("fill_overpush_ignored", 32'(count), NR + 3);
    @(posedge clk); #1;
    pbase = pops;
    drain("fill_drain_done");
    chk("fill_drain_pops", 32'(pops - pbase), NR + 3);

    // Continuous streaming
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 100; i++) push_word(W'(16'h1000 + i));
      end
    join_none
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin lat++; @(negedge clk); end
    chk("stream_latency", 32'(lat), 3);
    gaps = 0;
    for (int i = 0; i < 100; i++) begin
      if (!(out_valid && out_ready)) gaps++;
      @(negedge clk);
    end
    chk("stream_gaps", 32'(gaps), 0);
    wait fork;
    repeat (3) @(negedge clk);
    chk("stream_empty_count", 32'(count), 0);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Random valid gaps and 30% output backpressure; pointers wrap on NR=5
    for (int phase = 0; phase < 2; phase++) begin
      done_push = 1'b0;
      fork
        begin
          for (int i = 0; i < 23 + phase * 17; i++) begin
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
            push_word(W'(16'h2000 + phase * 16'h100 + i));
          end
          done_push = 1'b1;
        end
        begin
          t = 0;
          while (!(done_push && exp_q.size() == 0 && !out_valid) && t < 3000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(99) >= 30);
            t++;
          end
          chk("rand_drain_done", 32'(t < 3000), 1);
        end
      join
      out_ready = 1'b0;
      chk("rand_queue_empty", 32'(exp_q.size()), 0);
    end

    // Reset while a read is in flight
    @(posedge clk); #1;
    push_word(16'h0051);
    push_word(16'h0052);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_count", 32'(count), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    chk("mrst_web", 32'(sram_web), 1);
    chk("mrst_reb", 32'(sram_reb), 1);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    pbase = pops;
    push_word(16'h003C);
    drain("mrst_drain_done");
    chk("mrst_pops", 32'(pops - pbase), 1);
    chk("mrst_first_word", 32'(last_pop), 32'h003C);
    @(negedge clk);
    chk("mrst_final_count", 32'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
